// File: rtl/rat_int_pkg.sv
// -----------------------------------------------------------------------------
// rat_int_pkg
// Shared types and constants for the RAT CPU interrupt controller.
//   int_state_t : controller state (IDLE = normal execution, SERVICE = inside
//                 an interrupt service routine, between accept and return).
//   MISS_W_DEF  : default width of the saturating missed-request counter.
// -----------------------------------------------------------------------------
package rat_int_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    SERVICE = 1'b1
  } int_state_t;

  localparam int MISS_W_DEF = 8;

endpackage

// File: rtl/sync_edge.sv
// -----------------------------------------------------------------------------
// sync_edge
// Two-flop synchronizer for an asynchronous request line followed by a
// rising-edge detector. All flops reset to 0, so a line that is already high
// when reset is released is reported as a rising edge.
// Ports:
//   i_clk    : system clock
//   i_rst_n  : asynchronous active-low reset
//   i_async  : asynchronous input line
//   o_edge   : one-cycle pulse, high while sync2=1 and its delayed copy=0
// -----------------------------------------------------------------------------
module sync_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_edge
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_async;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_edge = r_sync2 & ~r_prev;

endmodule

// File: rtl/rat_int_ctrl.sv
// -----------------------------------------------------------------------------
// rat_int_ctrl
// Interrupt controller for the RAT CPU. Synchronizes INTR, latches a single
// pending request, gates it with the interrupt-enable flag, saves C/Z into
// shadow registers on accept and asks the flag register to restore them on
// return.
// Ports:
//   CLK, RST_N    : clock, asynchronous active-low reset
//   INTR          : asynchronous interrupt line, rising edge = request
//   I_SET / I_CLR : SEI / CLI (honoured only in IDLE, CLI wins)
//   INT_ACK       : control unit entering the interrupt cycle
//   RETI, RETI_IE : return from interrupt; RETI_IE=1 re-enables interrupts
//   C_FLAG/Z_FLAG : live flags, captured into the shadows on accept
//   INT_PEND      : request to the control unit
//   I_FLAG        : interrupt-enable flag
//   SHAD_C/SHAD_Z : shadow flags
//   FLG_SHAD_SEL  : one-cycle pulse after return, flag register loads shadows
//   MISSED        : saturating count of request edges dropped while pending
// Handshake: INT_ACK and RETI are single-cycle strobes sampled on the rising
// edge; accept is only honoured while INT_PEND is high, return only in
// SERVICE. Every output is a register or a function of registers only, so
// there is no combinational path from INT_ACK/RETI to an output.
// -----------------------------------------------------------------------------
module rat_int_ctrl
  import rat_int_pkg::*;
#(
  parameter int MISS_W = MISS_W_DEF
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              INTR,
  input  logic              I_SET,
  input  logic              I_CLR,
  input  logic              INT_ACK,
  input  logic              RETI,
  input  logic              RETI_IE,
  input  logic              C_FLAG,
  input  logic              Z_FLAG,
  output logic              INT_PEND,
  output logic              I_FLAG,
  output logic              SHAD_C,
  output logic              SHAD_Z,
  output logic              FLG_SHAD_SEL,
  output logic [MISS_W-1:0] MISSED
);

  int_state_t        r_state;
  logic              r_pending;
  logic              r_i_flag;
  logic              r_shad_c;
  logic              r_shad_z;
  logic              r_shad_sel;
  logic [MISS_W-1:0] r_missed;

  logic w_edge;
  logic w_int_pend;
  logic w_accept;

  sync_edge u_sync_edge (
    .i_clk   (CLK),
    .i_rst_n (RST_N),
    .i_async (INTR),
    .o_edge  (w_edge)
  );

  assign w_int_pend = r_pending & r_i_flag & (r_state == IDLE);
  // w_int_pend already implies IDLE, so this is the full accept condition.
  assign w_accept   = INT_ACK & w_int_pend;

  // Control FSM with its registered outputs (I_FLAG, shadows, restore pulse).
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= IDLE;
      r_i_flag   <= 1'b0;
      r_shad_c   <= 1'b0;
      r_shad_z   <= 1'b0;
      r_shad_sel <= 1'b0;
    end else begin
      r_shad_sel <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state  <= SERVICE;
            r_shad_c <= C_FLAG;
            r_shad_z <= Z_FLAG;
            r_i_flag <= 1'b0;
          end else if (I_CLR) begin
            r_i_flag <= 1'b0;
          end else if (I_SET) begin
            r_i_flag <= 1'b1;
          end
        end
        SERVICE: begin
          // SEI/CLI are ignored here; only the return can change I_FLAG.
          if (RETI) begin
            r_state    <= IDLE;
            r_i_flag   <= RETI_IE;
            r_shad_sel <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Pending latch and missed counter. A new edge wins over the clear done by
  // an accept in the same cycle; that edge is not a miss since the old
  // request is being consumed.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pending <= 1'b0;
      r_missed  <= '0;
    end else begin
      if (w_edge) begin
        r_pending <= 1'b1;
        if (r_pending && !w_accept && (r_missed != '1)) begin
          r_missed <= r_missed + MISS_W'(1);
        end
      end else if (w_accept) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign INT_PEND     = w_int_pend;
  assign I_FLAG       = r_i_flag;
  assign SHAD_C       = r_shad_c;
  assign SHAD_Z       = r_shad_z;
  assign FLG_SHAD_SEL = r_shad_sel;
  assign MISSED       = r_missed;

endmodule

// File: tb/tb_rat_int_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rat_int_ctrl
// Directed bench for rat_int_ctrl. Inputs change 1 time unit after the rising
// edge and outputs are sampled at that same point, so each tick() advances
// exactly one clock edge. Expected values are hand-derived from the timing
// rules of the controller.
// -----------------------------------------------------------------------------
module tb_rat_int_ctrl;

  localparam int MISS_W = 8;

  logic              CLK;
  logic              RST_N;
  logic              INTR;
  logic              I_SET;
  logic              I_CLR;
  logic              INT_ACK;
  logic              RETI;
  logic              RETI_IE;
  logic              C_FLAG;
  logic              Z_FLAG;
  logic              INT_PEND;
  logic              I_FLAG;
  logic              SHAD_C;
  logic              SHAD_Z;
  logic              FLG_SHAD_SEL;
  logic [MISS_W-1:0] MISSED;

  int total = 0;
  int bad   = 0;

  rat_int_ctrl #(.MISS_W(MISS_W)) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .INTR         (INTR),
    .I_SET        (I_SET),
    .I_CLR        (I_CLR),
    .INT_ACK      (INT_ACK),
    .RETI         (RETI),
    .RETI_IE      (RETI_IE),
    .C_FLAG       (C_FLAG),
    .Z_FLAG       (Z_FLAG),
    .INT_PEND     (INT_PEND),
    .I_FLAG       (I_FLAG),
    .SHAD_C       (SHAD_C),
    .SHAD_Z       (SHAD_Z),
    .FLG_SHAD_SEL (FLG_SHAD_SEL),
    .MISSED       (MISSED)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic intr_pulse();
    INTR = 1'b1;
    tick();
    INTR = 1'b0;
    tick();
  endtask

  task automatic strobe_i_set();
    I_SET = 1'b1;
    tick();
    I_SET = 1'b0;
  endtask

  task automatic strobe_ack(input logic c, input logic z);
    C_FLAG  = c;
    Z_FLAG  = z;
    INT_ACK = 1'b1;
    tick();
    INT_ACK = 1'b0;
  endtask

  task automatic strobe_reti(input logic ie);
    RETI    = 1'b1;
    RETI_IE = ie;
    tick();
    RETI    = 1'b0;
    RETI_IE = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RST_N = 1'b0; INTR = 1'b0; I_SET = 1'b0; I_CLR = 1'b0; INT_ACK = 1'b0;
    RETI = 1'b0; RETI_IE = 1'b0; C_FLAG = 1'b0; Z_FLAG = 1'b0;
    tick(); tick();
    total++; if (INT_PEND !== 1'b0) begin bad++; $display("FAIL reset_int_pend: got %b want 0", INT_PEND); end
    total++; if (I_FLAG !== 1'b0) begin bad++; $display("FAIL reset_i_flag: got %b want 0", I_FLAG); end
    total++; if (SHAD_C !== 1'b0) begin bad++; $display("FAIL reset_shad_c: got %b want 0", SHAD_C); end
    total++; if (SHAD_Z !== 1'b0) begin bad++; $display("FAIL reset_shad_z: got %b want 0", SHAD_Z); end
    total++; if (FLG_SHAD_SEL !== 1'b0) begin bad++; $display("FAIL reset_shad_sel: got %b want 0", FLG_SHAD_SEL); end
    total++; if (MISSED !== 8'd0) begin bad++; $display("FAIL reset_missed: got %0d want 0", MISSED); end
    RST_N = 1'b1;
    tick();
  endtask

  task automatic test_latency();
    strobe_i_set();
    tick();
    total++; if (I_FLAG !== 1'b1) begin bad++; $display("FAIL sei_i_flag: got %b want 1", I_FLAG); end
    INTR = 1'b1;
    tick();  // sync1 = 1
    total++; if (INT_PEND !== 1'b0) begin bad++; $display("FAIL lat_edge1: got %b want 0", INT_PEND); end
    tick();  // sync2 = 1
    total++; if (INT_PEND !== 1'b0) begin bad++; $display("FAIL lat_edge2: got %b want 0", INT_PEND); end
    tick();  // pending = 1
    total++; if (INT_PEND !== 1'b1) begin bad++; $display("FAIL lat_edge3: got %b want 1", INT_PEND); end
    INTR = 1'b0;
    tick(); tick(); tick();
    total++; if (INT_PEND !== 1'b1) begin bad++; $display("FAIL lat_hold: got %b want 1", INT_PEND); end
  endtask

  task automatic test_accept_return();
    strobe_ack(1'b1, 1'b0);
    C_FLAG = 1'b0; Z_FLAG = 1'b1;  // live flags move; shadows must not
    total++; if (SHAD_C !== 1'b1) begin bad++; $display("FAIL acc_shad_c: got %b want 1", SHAD_C); end
    total++; if (SHAD_Z !== 1'b0) begin bad++; $display("FAIL acc_shad_z: got %b want 0", SHAD_Z); end
    total++; if (I_FLAG !== 1'b0) begin bad++; $display("FAIL acc_i_flag: got %b want 0", I_FLAG); end
    total++; if (INT_PEND !== 1'b0) begin bad++; $display("FAIL acc_int_pend: got %b want 0", INT_PEND); end
    total++; if (FLG_SHAD_SEL !== 1'b0) begin bad++; $display("FAIL acc_no_sel: got %b want 0", FLG_SHAD_SEL); end
    tick();
    strobe_reti(1'b1);
    total++; if (FLG_SHAD_SEL !== 1'b1) begin bad++; $display("FAIL ret_sel: got %b want 1", FLG_SHAD_SEL); end
    total++; if (I_FLAG !== 1'b1) begin bad++; $display("FAIL ret_i_flag: got %b want 1", I_FLAG); end
    total++; if (SHAD_C !== 1'b1) begin bad++; $display("FAIL ret_shad_hold: got %b want 1", SHAD_C); end
    tick();
    total++; if (FLG_SHAD_SEL !== 1'b0) begin bad++; $display("FAIL ret_sel_once: got %b want 0", FLG_SHAD_SEL); end
    total++; if (INT_PEND !== 1'b0) begin bad++; $display("FAIL ret_no_pend: got %b want 0", INT_PEND); end
  endtask

  task automatic test_service_edge();
    intr_pulse();
    tick();
    total++; if (INT_PEND !== 1'b1) begin bad++; $display("FAIL pulse_pend: got %b want 1", INT_PEND); end
    strobe_ack(1'b0, 1'b1);
    total++; if (SHAD_C !== 1'b0) begin bad++; $display("FAIL svc_shad_c: got %b want 0", SHAD_C); end
    total++; if (SHAD_Z !== 1'b1) begin bad++; $display("FAIL svc_shad_z: got %b want 1", SHAD_Z); end
    intr_pulse();
    tick(); tick();
    total++; if (INT_PEND !== 1'b0) begin bad++; $display("FAIL svc_pend_masked: got %b want 0", INT_PEND); end
    strobe_i_set();
    total++; if (I_FLAG !== 1'b0) begin bad++; $display("FAIL svc_sei_ignored: got %b want 0", I_FLAG); end
    strobe_reti(1'b0);
    total++; if (I_FLAG !== 1'b0) begin bad++; $display("FAIL retid_i_flag: got %b want 0", I_FLAG); end
    total++; if (INT_PEND !== 1'b0) begin bad++; $display("FAIL retid_pend: got %b want 0", INT_PEND); end
    total++; if (FLG_SHAD_SEL !== 1'b1) begin bad++; $display("FAIL retid_sel: got %b want 1", FLG_SHAD_SEL); end
    strobe_i_set();
    total++; if (INT_PEND !== 1'b1) begin bad++; $display("FAIL retid_sei_pend: got %b want 1", INT_PEND); end
    total++; if (MISSED !== 8'd0) begin bad++; $display("FAIL svc_missed: got %0d want 0", MISSED); end
  endtask

  // New edge sampled on the same edge as the accept: pending stays set and
  // nothing is counted as missed.
  task automatic test_edge_with_accept();
    INTR = 1'b1;
    tick();            // sync1
    INTR = 1'b0;
    tick();            // sync2 -> edge visible this cycle
    strobe_ack(1'b1, 1'b1);
    total++; if (SHAD_C !== 1'b1) begin bad++; $display("FAIL coinc_shad_c: got %b want 1", SHAD_C); end
    total++; if (SHAD_Z !== 1'b1) begin bad++; $display("FAIL coinc_shad_z: got %b want 1", SHAD_Z); end
    total++; if (MISSED !== 8'd0) begin bad++; $display("FAIL coinc_missed: got %0d want 0", MISSED); end
    total++; if (INT_PEND !== 1'b0) begin bad++; $display("FAIL coinc_svc_pend: got %b want 0", INT_PEND); end
    tick();
    strobe_reti(1'b1);
    total++; if (INT_PEND !== 1'b1) begin bad++; $display("FAIL coinc_retie_pend: got %b want 1", INT_PEND); end
  endtask

  task automatic test_missed();
    // SEI and CLI together: CLI wins, request stays pending but masked.
    I_SET = 1'b1; I_CLR = 1'b1;
    tick();
    I_SET = 1'b0; I_CLR = 1'b0;
    total++; if (I_FLAG !== 1'b0) begin bad++; $display("FAIL sei_cli_both: got %b want 0", I_FLAG); end
    total++; if (INT_PEND !== 1'b0) begin bad++; $display("FAIL masked_pend: got %b want 0", INT_PEND); end
    for (int i = 0; i < 10; i++) intr_pulse();
    tick(); tick(); tick();
    total++; if (MISSED !== 8'd10) begin bad++; $display("FAIL missed_10: got %0d want 10", MISSED); end
    for (int i = 0; i < 290; i++) intr_pulse();
    tick(); tick(); tick();
    total++; if (MISSED !== 8'd255) begin bad++; $display("FAIL missed_sat: got %0d want 255", MISSED); end
    for (int i = 0; i < 5; i++) intr_pulse();
    tick(); tick(); tick();
    total++; if (MISSED !== 8'd255) begin bad++; $display("FAIL missed_hold: got %0d want 255", MISSED); end
  endtask

  task automatic test_reti_idle();
    strobe_reti(1'b1);
    total++; if (FLG_SHAD_SEL !== 1'b0) begin bad++; $display("FAIL idle_reti_sel: got %b want 0", FLG_SHAD_SEL); end
    total++; if (I_FLAG !== 1'b0) begin bad++; $display("FAIL idle_reti_i_flag: got %b want 0", I_FLAG); end
  endtask

  task automatic test_reset_mid_service();
    strobe_i_set();
    total++; if (INT_PEND !== 1'b1) begin bad++; $display("FAIL pre_rst_pend: got %b want 1", INT_PEND); end
    strobe_ack(1'b1, 1'b1);
    total++; if (SHAD_C !== 1'b1) begin bad++; $display("FAIL pre_rst_shad: got %b want 1", SHAD_C); end
    INTR = 1'b1;
    #3;
    RST_N = 1'b0;
    #1;  // mid-cycle: outputs must already be cleared
    total++; if (SHAD_C !== 1'b0) begin bad++; $display("FAIL arst_shad_c: got %b want 0", SHAD_C); end
    total++; if (SHAD_Z !== 1'b0) begin bad++; $display("FAIL arst_shad_z: got %b want 0", SHAD_Z); end
    total++; if (MISSED !== 8'd0) begin bad++; $display("FAIL arst_missed: got %0d want 0", MISSED); end
    total++; if (I_FLAG !== 1'b0) begin bad++; $display("FAIL arst_i_flag: got %b want 0", I_FLAG); end
    total++; if (INT_PEND !== 1'b0) begin bad++; $display("FAIL arst_pend: got %b want 0", INT_PEND); end
    tick(); tick();
    RST_N = 1'b1;  // INTR already high: must be seen as a rising edge
    strobe_i_set();  // sync1
    total++; if (I_FLAG !== 1'b1) begin bad++; $display("FAIL post_rst_sei: got %b want 1", I_FLAG); end
    tick();          // sync2
    total++; if (INT_PEND !== 1'b0) begin bad++; $display("FAIL post_rst_early: got %b want 0", INT_PEND); end
    tick();          // pending
    total++; if (INT_PEND !== 1'b1) begin bad++; $display("FAIL post_rst_edge: got %b want 1", INT_PEND); end
    INTR = 1'b0;
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_latency();
    test_accept_return();
    test_service_edge();
    test_edge_with_accept();
    test_missed();
    test_reti_idle();
    test_reset_mid_service();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
